// File: rtl/hdmi_packet_pkg.sv
// Shared types, constants and the BCH(64,56)/(32,24) LFSR step for the
// HDMI data-island packet receiver.
package hdmi_packet_pkg;

  typedef logic [23:0] header_t;
  typedef logic [55:0] subpacket_t;

  localparam int         PACKET_PIXELS    = 32;
  localparam logic [7:0] BCH_POLY         = 8'b1000_0011;
  localparam int         HEADER_DATA_BITS = 24;
  localparam int         SUB_DATA_BITS    = 56;

  localparam logic [7:0] ACR          = 8'h01;
  localparam logic [7:0] AUDIO_SAMPLE = 8'h02;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } rx_state_e;

  // One bit of G(x) = 1 + x^6 + x^7 + x^8, data taken in transmission order.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
    return (ecc >> 1) ^ ((ecc[0] ^ d) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bch_ecc_accumulator.sv
// BCH parity accumulator for one packet field; takes BITS_PER_CYCLE data
// bits per pixel, lowest-numbered bit first.
module bch_ecc_accumulator
  import hdmi_packet_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk_pixel,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [BITS_PER_CYCLE-1:0] data,
  output logic [7:0]                ecc
);

  logic [7:0] ecc_q, ecc_d;

  // NOTE: blocking assignments inside always_comb are intentional: each bit
  // step consumes the result of the previous one within the same pixel.
  always_comb begin
    ecc_d = clear ? 8'h00 : ecc_q;
    if (enable) begin
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
        ecc_d = bch_step(ecc_d, data[b]);
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ecc_q <= 8'h00;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc = ecc_q;

endmodule

// File: rtl/packet_receiver.sv
// HDMI data-island packet receiver: reassembles header and four subpackets
// from TERC4 nibbles. Define PACKET_RECEIVER_ECC_EN to build BCH checking.
module packet_receiver
  import hdmi_packet_pkg::*;
(
  input  logic            clk_pixel,
  input  logic            reset_n,
  input  logic            data_island_active,
  input  logic [3:0]      ch0_terc4,
  input  logic [3:0]      ch1_terc4,
  input  logic [3:0]      ch2_terc4,
  output logic            packet_valid,
  output logic [23:0]     header,
  output logic [3:0][55:0] sub,
  output logic            header_error,
  output logic [3:0]      sub_error,
  output logic            packet_aborted
);

  localparam int               IDX_W    = $clog2(PACKET_PIXELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_PIXELS - 1);

  rx_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, pix_idx;
  logic                   marker_low, last_pixel, abort_d;

  logic [30:0]            hdr_sr_q;
  logic [31:0]            hdr_sr_d;
  logic [3:0][61:0]       sub_sr_q;
  logic [3:0][63:0]       sub_sr_d;

  logic                   packet_valid_q, packet_aborted_q;
  header_t                header_q;
  logic [3:0][55:0]       sub_q;

  // Sync bits on ch0 carry no packet content.
  logic                   unused_sync;
  assign unused_sync = ^ch0_terc4[1:0];

  // A low start marker always defines pixel 0, whatever idx says.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    abort_d    = 1'b0;
    marker_low = data_island_active && !ch0_terc4[3];
    pix_idx    = marker_low ? '0 : idx_q;
    last_pixel = data_island_active && (pix_idx == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        if (data_island_active) begin
          state_d = ST_COLLECT;
          idx_d   = pix_idx + IDX_W'(1);
        end else begin
          idx_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (!data_island_active) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          abort_d = (idx_q != '0);
        end else begin
          idx_d   = pix_idx + IDX_W'(1);
          abort_d = marker_low && (idx_q != '0);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // The final pixel's bits enter through _d, so the stored part is one short.
  always_comb begin
    hdr_sr_d = {ch0_terc4[2], hdr_sr_q};
    for (int k = 0; k < 4; k++) begin
      sub_sr_d[k] = {ch2_terc4[k], ch1_terc4[k], sub_sr_q[k]};
    end
  end

  // NOTE: the shift registers carry no reset; every bit is rewritten during
  // a packet before it can be loaded into the outputs.
  always_ff @(posedge clk_pixel) begin
    if (data_island_active) begin
      hdr_sr_q <= hdr_sr_d[31:1];
      for (int k = 0; k < 4; k++) begin
        sub_sr_q[k] <= sub_sr_d[k][63:2];
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      packet_valid_q   <= 1'b0;
      packet_aborted_q <= 1'b0;
      header_q         <= '0;
      sub_q            <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      packet_valid_q   <= last_pixel;
      packet_aborted_q <= abort_d;
      if (last_pixel) begin
        header_q <= hdr_sr_d[HEADER_DATA_BITS-1:0];
        for (int k = 0; k < 4; k++) begin
          sub_q[k] <= sub_sr_d[k][SUB_DATA_BITS-1:0];
        end
      end
    end
  end

  assign packet_valid   = packet_valid_q;
  assign packet_aborted = packet_aborted_q;
  assign header         = header_q;
  assign sub            = sub_q;

`ifdef PACKET_RECEIVER_ECC_EN
  localparam logic [IDX_W-1:0] HDR_PAR_IDX = IDX_W'(HEADER_DATA_BITS);
  localparam logic [IDX_W-1:0] SUB_PAR_IDX = IDX_W'(SUB_DATA_BITS / 2);

  logic             first_pixel, hdr_ecc_en, sub_ecc_en;
  logic [7:0]       hdr_ecc;
  logic [3:0][7:0]  sub_ecc;
  logic [3:0]       sub_mismatch;
  logic             header_error_q;
  logic [3:0]       sub_error_q;

  assign first_pixel = data_island_active && (pix_idx == '0);
  assign hdr_ecc_en  = data_island_active && (pix_idx < HDR_PAR_IDX);
  assign sub_ecc_en  = data_island_active && (pix_idx < SUB_PAR_IDX);

  bch_ecc_accumulator #(.BITS_PER_CYCLE(1)) u_hdr_ecc (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clear     (first_pixel),
    .enable    (hdr_ecc_en),
    .data      (ch0_terc4[2]),
    .ecc       (hdr_ecc)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
    bch_ecc_accumulator #(.BITS_PER_CYCLE(2)) u_sub_ecc (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clear     (first_pixel),
      .enable    (sub_ecc_en),
      .data      ({ch2_terc4[k], ch1_terc4[k]}),
      .ecc       (sub_ecc[k])
    );
    assign sub_mismatch[k] = (sub_sr_d[k][63:56] != sub_ecc[k]);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      header_error_q <= 1'b0;
      sub_error_q    <= 4'b0000;
    end else if (last_pixel) begin
      header_error_q <= (hdr_sr_d[31:24] != hdr_ecc);
      sub_error_q    <= sub_mismatch;
    end
  end

  assign header_error = header_error_q;
  assign sub_error    = sub_error_q;
`else
  assign header_error = 1'b0;
  assign sub_error    = 4'b0000;
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver: packets built from header/subpacket
// values plus computed BCH parity, outputs compared against that model.
`timescale 1ns/1ps
module tb_packet_receiver;
  import hdmi_packet_pkg::*;

`ifdef PACKET_RECEIVER_ECC_EN
  localparam bit ECC_EN = 1'b1;
`else
  localparam bit ECC_EN = 1'b0;
`endif

  logic             clk_pixel = 1'b0;
  logic             reset_n = 1'b0;
  logic             data_island_active = 1'b0;
  logic [3:0]       ch0_terc4 = 4'b1000;
  logic [3:0]       ch1_terc4 = 4'b0000;
  logic [3:0]       ch2_terc4 = 4'b0000;
  logic             packet_valid;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             header_error;
  logic [3:0]       sub_error;
  logic             packet_aborted;

  packet_receiver dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .data_island_active (data_island_active),
    .ch0_terc4          (ch0_terc4),
    .ch1_terc4          (ch1_terc4),
    .ch2_terc4          (ch2_terc4),
    .packet_valid       (packet_valid),
    .header             (header),
    .sub                (sub),
    .header_error       (header_error),
    .sub_error          (sub_error),
    .packet_aborted     (packet_aborted)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int               cyc;
    header_t          hdr;
    logic [3:0][55:0] sub;
    logic             he;
    logic [3:0]       se;
  } rx_rec_t;

  int      checks = 0;
  int      errors = 0;
  int      cycle  = 0;
  rx_rec_t valid_q[$];
  int      abort_q[$];
  rx_rec_t last_exp;

  always @(posedge clk_pixel) cycle <= cycle + 1;

  always @(negedge clk_pixel) begin : monitor
    rx_rec_t r;
    if (packet_valid) begin
      r.cyc = cycle;
      r.hdr = header;
      r.sub = sub;
      r.he  = header_error;
      r.se  = sub_error;
      valid_q.push_back(r);
    end
    if (packet_aborted) abort_q.push_back(cycle);
  end

  function automatic logic [7:0] bch(input logic [63:0] v, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) e = (e >> 1) ^ ((e[0] ^ v[i]) ? BCH_POLY : 8'h00);
    return e;
  endfunction

  function automatic logic [252:0] pack_rec(input rx_rec_t r);
    return {r.hdr, r.sub, r.he, r.se};
  endfunction

  task automatic drive(input logic act, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [3:0] c2);
    @(negedge clk_pixel);
    #1;
    data_island_active = act;
    ch0_terc4 = c0;
    ch1_terc4 = c1;
    ch2_terc4 = c2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b1000, 4'b0000, 4'b0000);
  endtask

  // Drives the first n_pix pixels of a packet; exp is what a full packet reports.
  task automatic send_packet(input header_t h, input logic [3:0][55:0] s,
                             input logic [31:0] hflip, input logic [3:0][63:0] sflip,
                             input int n_pix, output int start_cyc, output rx_rec_t exp);
    logic [31:0]      hw;
    logic [3:0][63:0] sw;
    logic [3:0]       c1, c2;
    logic [1:0]       sync;
    hw = {bch(64'(h), HEADER_DATA_BITS), h} ^ hflip;
    for (int k = 0; k < 4; k++) sw[k] = {bch(64'(s[k]), SUB_DATA_BITS), s[k]} ^ sflip[k];
    start_cyc = 0;
    for (int i = 0; i < n_pix; i++) begin
      for (int k = 0; k < 4; k++) begin
        c1[k] = sw[k][2*i];
        c2[k] = sw[k][2*i+1];
      end
      sync = 2'($urandom);
      drive(1'b1, {(i != 0), hw[i], sync}, c1, c2);
      if (i == 0) start_cyc = cycle;
    end
    exp.cyc = start_cyc + PACKET_PIXELS;
    exp.hdr = hw[23:0];
    exp.he  = ECC_EN && (bch(64'(hw[23:0]), HEADER_DATA_BITS) != hw[31:24]);
    for (int k = 0; k < 4; k++) begin
      exp.sub[k] = sw[k][55:0];
      exp.se[k]  = ECC_EN && (bch(64'(sw[k][55:0]), SUB_DATA_BITS) != sw[k][63:56]);
    end
  endtask

  function automatic logic [3:0][55:0] rand_subs();
    logic [3:0][55:0] s;
    for (int k = 0; k < 4; k++) s[k] = subpacket_t'({$urandom, $urandom});
    return s;
  endfunction

  task automatic clear_logs();
    valid_q.delete();
    abort_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_pixel);
    #1;
    checks++; if (packet_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", packet_valid); end
    checks++; if (packet_aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got=%b exp=0", packet_aborted); end
    checks++; if (header !== 24'h0) begin errors++; $display("FAIL reset_header got=%h exp=0", header); end
    checks++; if (sub !== '0) begin errors++; $display("FAIL reset_sub got=%h exp=0", sub); end
    checks++; if (header_error !== 1'b0) begin errors++; $display("FAIL reset_header_error got=%b exp=0", header_error); end
    checks++; if (sub_error !== 4'b0) begin errors++; $display("FAIL reset_sub_error got=%b exp=0", sub_error); end
    reset_n = 1'b1;
  endtask

  task automatic test_acr();
    logic [3:0][55:0] s;
    rx_rec_t exp;
    int st;
    idle(2);
    clear_logs();
    s = '0;
    s[0] = 56'h00_0C_00_18_80_00_00;
    send_packet({16'h0000, ACR}, s, '0, '0, PACKET_PIXELS, st, exp);
    idle(3);
    checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL acr_count got=%0d exp=1", valid_q.size()); end
    checks++; if (abort_q.size() != 0) begin errors++; $display("FAIL acr_abort got=%0d exp=0", abort_q.size()); end
    if (valid_q.size() == 1) begin
      checks++; if (valid_q[0].cyc != exp.cyc) begin errors++; $display("FAIL acr_latency got=%0d exp=%0d", valid_q[0].cyc - st, exp.cyc - st); end
      checks++; if (valid_q[0].hdr !== 24'h000001) begin errors++; $display("FAIL acr_header got=%h exp=000001", valid_q[0].hdr); end
      checks++; if (valid_q[0].he !== 1'b0 || valid_q[0].se !== 4'b0) begin errors++; $display("FAIL acr_errors got=%b/%b exp=0/0000", valid_q[0].he, valid_q[0].se); end
      checks++; if (pack_rec(valid_q[0]) !== pack_rec(exp)) begin errors++; $display("FAIL acr_content got=%h exp=%h", pack_rec(valid_q[0]), pack_rec(exp)); end
    end
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    rx_rec_t exp[2];
    int st[2];
    idle(2);
    clear_logs();
    for (int p = 0; p < 2; p++)
      send_packet({16'($urandom), AUDIO_SAMPLE}, rand_subs(), '0, '0, PACKET_PIXELS, st[p], exp[p]);
    idle(3);
    checks++; if (valid_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", valid_q.size()); end
    checks++; if (abort_q.size() != 0) begin errors++; $display("FAIL b2b_abort got=%0d exp=0", abort_q.size()); end
    if (valid_q.size() == 2) begin
      checks++; if (valid_q[1].cyc - valid_q[0].cyc != 32) begin errors++; $display("FAIL b2b_spacing got=%0d exp=32", valid_q[1].cyc - valid_q[0].cyc); end
      for (int p = 0; p < 2; p++) begin
        checks++; if (pack_rec(valid_q[p]) !== pack_rec(exp[p])) begin errors++; $display("FAIL b2b_content%0d got=%h exp=%h", p, pack_rec(valid_q[p]), pack_rec(exp[p])); end
      end
    end
    last_exp = exp[1];
  endtask

  task automatic test_parity_errors();
    logic [3:0][63:0] sflip;
    rx_rec_t exp;
    int st;
    idle(2);
    clear_logs();
    sflip = '0;
    sflip[2] = 64'd1 << 10;
    send_packet({16'($urandom), AUDIO_SAMPLE}, rand_subs(), 32'd1 << 27, sflip, PACKET_PIXELS, st, exp);
    idle(3);
    checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL perr_count got=%0d exp=1", valid_q.size()); end
    if (valid_q.size() == 1) begin
      checks++; if (valid_q[0].he !== ECC_EN) begin errors++; $display("FAIL perr_header_error got=%b exp=%b", valid_q[0].he, ECC_EN); end
      checks++; if (valid_q[0].se !== (ECC_EN ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL perr_sub_error got=%b exp=%b", valid_q[0].se, ECC_EN ? 4'b0100 : 4'b0000); end
      checks++; if (pack_rec(valid_q[0]) !== pack_rec(exp)) begin errors++; $display("FAIL perr_content got=%h exp=%h", pack_rec(valid_q[0]), pack_rec(exp)); end
    end
    last_exp = exp;
  endtask

  task automatic test_abort();
    rx_rec_t exp;
    int st, drop;
    idle(2);
    clear_logs();
    send_packet(header_t'($urandom), rand_subs(), '0, '0, 17, st, exp);
    idle(1);
    drop = cycle;
    idle(40);
    checks++; if (abort_q.size() != 1) begin errors++; $display("FAIL abort_count got=%0d exp=1", abort_q.size()); end
    if (abort_q.size() == 1) begin
      checks++; if (abort_q[0] != drop + 1) begin errors++; $display("FAIL abort_timing got=%0d exp=%0d", abort_q[0] - drop, 1); end
    end
    checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL abort_valid got=%0d exp=0", valid_q.size()); end
    checks++; if (header !== last_exp.hdr || sub !== last_exp.sub) begin errors++; $display("FAIL abort_hold got=%h exp=%h", {header, sub}, {last_exp.hdr, last_exp.sub}); end
  endtask

  task automatic test_resync();
    rx_rec_t exp, dummy;
    int st, m;
    idle(2);
    clear_logs();
    send_packet(header_t'($urandom), rand_subs(), '0, '0, 9, st, dummy);
    send_packet({16'($urandom), AUDIO_SAMPLE}, rand_subs(), '0, '0, PACKET_PIXELS, m, exp);
    idle(3);
    checks++; if (abort_q.size() != 1) begin errors++; $display("FAIL resync_abort_count got=%0d exp=1", abort_q.size()); end
    if (abort_q.size() == 1) begin
      checks++; if (abort_q[0] != m + 1) begin errors++; $display("FAIL resync_abort_timing got=%0d exp=1", abort_q[0] - m); end
    end
    checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL resync_count got=%0d exp=1", valid_q.size()); end
    if (valid_q.size() == 1) begin
      checks++; if (valid_q[0].cyc != m + 32) begin errors++; $display("FAIL resync_latency got=%0d exp=32", valid_q[0].cyc - m); end
      checks++; if (pack_rec(valid_q[0]) !== pack_rec(exp)) begin errors++; $display("FAIL resync_content got=%h exp=%h", pack_rec(valid_q[0]), pack_rec(exp)); end
    end
    last_exp = exp;
  endtask

  task automatic test_reset_mid();
    rx_rec_t exp, dummy;
    int st;
    idle(2);
    send_packet(header_t'($urandom), rand_subs(), '0, '0, 20, st, dummy);
    @(negedge clk_pixel);
    #1;
    reset_n = 1'b0;
    data_island_active = 1'b0;
    repeat (2) @(negedge clk_pixel);
    #1;
    checks++; if ({packet_valid, packet_aborted, header, sub, header_error, sub_error} !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0", {packet_valid, packet_aborted, header, sub, header_error, sub_error});
    end
    reset_n = 1'b1;
    idle(2);
    clear_logs();
    send_packet(header_t'($urandom), rand_subs(), 32'd1 << 5, '0, PACKET_PIXELS, st, exp);
    idle(3);
    checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL midreset_count got=%0d exp=1", valid_q.size()); end
    checks++; if (abort_q.size() != 0) begin errors++; $display("FAIL midreset_abort got=%0d exp=0", abort_q.size()); end
    if (valid_q.size() == 1) begin
      checks++; if (pack_rec(valid_q[0]) !== pack_rec(exp)) begin errors++; $display("FAIL midreset_content got=%h exp=%h", pack_rec(valid_q[0]), pack_rec(exp)); end
    end
    last_exp = exp;
  endtask

  task automatic test_random();
    rx_rec_t exp[8];
    int st;
    logic [3:0][63:0] sflip;
    logic [31:0] hflip;
    idle(2);
    clear_logs();
    for (int p = 0; p < 8; p++) begin
      hflip = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      sflip = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) sflip[k] = 64'd1 << $urandom_range(0, 63);
      send_packet(header_t'($urandom), rand_subs(), hflip, sflip, PACKET_PIXELS, st, exp[p]);
      idle($urandom_range(0, 3));
    end
    idle(3);
    checks++; if (valid_q.size() != 8) begin errors++; $display("FAIL rand_count got=%0d exp=8", valid_q.size()); end
    checks++; if (abort_q.size() != 0) begin errors++; $display("FAIL rand_abort got=%0d exp=0", abort_q.size()); end
    if (valid_q.size() == 8) begin
      for (int p = 0; p < 8; p++) begin
        checks++; if (valid_q[p].cyc != exp[p].cyc) begin errors++; $display("FAIL rand_latency%0d got=%0d exp=%0d", p, valid_q[p].cyc, exp[p].cyc); end
        checks++; if (pack_rec(valid_q[p]) !== pack_rec(exp[p])) begin errors++; $display("FAIL rand_content%0d got=%h exp=%h", p, pack_rec(valid_q[p]), pack_rec(exp[p])); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_acr();
    test_back_to_back();
    test_parity_errors();
    test_abort();
    test_resync();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
